// File: rtl/prga.sv
// prga: ARC4 keystream stage; decrypts length-prefixed CT into PT while swapping S in place
module prga #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);
  typedef enum logic [3:0] {
    IDLE, RD_LEN, WR_LEN, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD, WR_PT, DONE
  } state_t;
  state_t     r_state, w_next;
  logic [1:0] r_wait;
  logic [7:0] r_i, r_j, r_k, r_len, r_si, r_sj, r_pad, r_ct;
  logic       w_rd, w_last;
  assign w_rd   = r_state inside {RD_LEN, RD_SI, RD_SJ, RD_PAD};
  assign w_last = r_wait == 2'(RD_LAT);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // read wait counter: zero in the issue cycle, capture happens when it reaches RD_LAT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_wait <= 2'd0;
    else        r_wait <= (w_rd && !w_last) ? r_wait + 2'd1 : 2'd0;
  // next state and memory port drive; addresses are held for the whole read so any latency works
  always_comb begin
    w_next    = r_state;
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        rdy    = 1'b1;
        w_next = en ? RD_LEN : IDLE;
      end
      RD_LEN: w_next = w_last ? WR_LEN : RD_LEN;
      WR_LEN: begin
        pt_wrdata = r_len;
        pt_wren   = 1'b1;
        w_next    = (r_len == 8'd0) ? DONE : RD_SI;
      end
      RD_SI: begin
        s_addr = r_i + 8'd1;
        w_next = w_last ? RD_SJ : RD_SI;
      end
      RD_SJ: begin
        s_addr = r_j;
        w_next = w_last ? WR_SI : RD_SJ;
      end
      WR_SI: begin
        s_addr   = r_i;
        s_wrdata = r_sj;
        s_wren   = 1'b1;
        w_next   = WR_SJ;
      end
      WR_SJ: begin
        s_addr   = r_j;
        s_wrdata = r_si;
        s_wren   = 1'b1;
        w_next   = RD_PAD;
      end
      RD_PAD: begin
        s_addr  = r_si + r_sj;
        ct_addr = r_k;
        w_next  = w_last ? WR_PT : RD_PAD;
      end
      WR_PT: begin
        pt_addr   = r_k;
        pt_wrdata = r_pad ^ r_ct;
        pt_wren   = 1'b1;
        w_next    = (r_k == r_len) ? DONE : RD_SI;
      end
      default: w_next = IDLE;
    endcase
  end
  // datapath: indices, length and captured read data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_i   <= 8'd0;
      r_j   <= 8'd0;
      r_k   <= 8'd0;
      r_len <= 8'd0;
      r_si  <= 8'd0;
      r_sj  <= 8'd0;
      r_pad <= 8'd0;
      r_ct  <= 8'd0;
    end else begin
      case (r_state)
        IDLE, DONE: if (en) begin
          r_i <= 8'd0;
          r_j <= 8'd0;
          r_k <= 8'd1;
        end
        RD_LEN: if (w_last) r_len <= ct_rddata;
        RD_SI: if (w_last) begin
          r_si <= s_rddata;
          r_i  <= r_i + 8'd1;
          r_j  <= r_j + s_rddata;
        end
        RD_SJ: if (w_last) r_sj <= s_rddata;
        RD_PAD: if (w_last) begin
          r_pad <= s_rddata;
          r_ct  <= ct_rddata;
        end
        WR_PT: if (r_k != r_len) r_k <= r_k + 8'd1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_prga.sv
// tb_prga: checks prga at RD_LAT=1 and RD_LAT=2 against an ARC4 reference model
module tb_prga;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  typedef struct {
    string       name;
    int          s_kind;
    int          len;
    logic [79:0] ct;
    logic [79:0] pt;
    int          npt;
    int          lat1;
    int          lat2;
    bit          pulse;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en [2];
  logic       rdy [2];
  logic [7:0] s_addr [2];
  logic [7:0] s_wrdata [2];
  logic       s_wren [2];
  logic [7:0] ct_addr [2];
  logic [7:0] pt_addr [2];
  logic [7:0] pt_wrdata [2];
  logic       pt_wren [2];
  logic [7:0] s_mem [2][256];
  logic [7:0] ct_mem [2][256];
  logic [7:0] pt_mem [2][256];
  logic [7:0] m_s [256];
  wr_t        sb [$];
  wr_t        mon_e;
  int         checks = 0;
  int         errors = 0;
  int         swr_cnt = 0;
  vec_t       vt [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    logic [7:0] sp1, sp2, cp1, cp2;
    prga #(.RD_LAT(g + 1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[g]),
      .rdy      (rdy[g]),
      .s_addr   (s_addr[g]),
      .s_rddata (g == 0 ? sp1 : sp2),
      .s_wrdata (s_wrdata[g]),
      .s_wren   (s_wren[g]),
      .ct_addr  (ct_addr[g]),
      .ct_rddata(g == 0 ? cp1 : cp2),
      .pt_addr  (pt_addr[g]),
      .pt_wrdata(pt_wrdata[g]),
      .pt_wren  (pt_wren[g])
    );
    always @(posedge clk) begin
      sp1 <= s_mem[g][s_addr[g]];
      sp2 <= sp1;
      cp1 <= ct_mem[g][ct_addr[g]];
      cp2 <= cp1;
      if (s_wren[g]) s_mem[g][s_addr[g]] = s_wrdata[g];
      if (pt_wren[g]) pt_mem[g][pt_addr[g]] = pt_wrdata[g];
    end
  end

  always @(negedge clk)
    for (int u = 0; u < 2; u++) begin
      if (s_wren[u] && pt_wren[u]) begin
        errors++;
        $display("FAIL wren_overlap inst=%0d: s_wren=1 pt_wren=1, required never both", u);
      end
      if (s_wren[u]) swr_cnt++;
      if (pt_wren[u]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pt_write inst=%0d: got addr=%02h data=%02h, required no write", u, pt_addr[u], pt_wrdata[u]);
        end else begin
          mon_e = sb.pop_front();
          if (pt_addr[u] !== mon_e.a || pt_wrdata[u] !== mon_e.d) begin
            errors++;
            $display("FAIL pt_write inst=%0d: got addr=%02h data=%02h, required addr=%02h data=%02h",
                     u, pt_addr[u], pt_wrdata[u], mon_e.a, mon_e.d);
          end
        end
      end
    end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic load_s(input int u, input int kind);
    logic [7:0] j, t;
    logic [7:0] key [3];
    key = '{8'h4B, 8'h65, 8'h79};
    for (int x = 0; x < 256; x++) s_mem[u][x] = 8'(x);
    if (kind == 1) begin
      j = 8'd0;
      for (int x = 0; x < 256; x++) begin
        j = j + s_mem[u][x] + key[x % 3];
        t = s_mem[u][x];
        s_mem[u][x] = s_mem[u][j];
        s_mem[u][j] = t;
      end
    end
    if (kind == 2)
      for (int x = 255; x > 0; x--) begin
        int r;
        r = $urandom_range(x, 0);
        t = s_mem[u][x];
        s_mem[u][x] = s_mem[u][r];
        s_mem[u][r] = t;
      end
  endtask

  task automatic start(input int u);
    logic [7:0] i, j, t, len;
    i = 8'd0;
    j = 8'd0;
    for (int x = 0; x < 256; x++) m_s[x] = s_mem[u][x];
    len = ct_mem[u][0];
    sb.push_back('{8'd0, len});
    for (int k = 1; k <= int'(len); k++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      t = m_s[i];
      m_s[i] = m_s[j];
      m_s[j] = t;
      t = m_s[i] + m_s[j];
      sb.push_back('{8'(k), ct_mem[u][k] ^ m_s[t]});
    end
    swr_cnt = 0;
    @(negedge clk);
    en[u] = 1'b1;
    @(posedge clk);
    #1 en[u] = 1'b0;
    check("busy_after_accept", int'(rdy[u]), 0);
  endtask

  task automatic finish(input int u, input int exp_lat, input bit pulse, input string nm);
    int cyc, bad;
    cyc = 0;
    bad = 0;
    while (!rdy[u] && cyc < exp_lat + 100) begin
      @(posedge clk);
      #1 cyc++;
      en[u] = pulse && cyc == 5;
    end
    en[u] = 1'b0;
    check({nm, " latency"}, cyc, exp_lat);
    check({nm, " sb_drained"}, sb.size(), 0);
    check({nm, " s_wren_pulses"}, swr_cnt, 2 * int'(ct_mem[u][0]));
    for (int x = 0; x < 256; x++) if (s_mem[u][x] !== m_s[x]) bad++;
    check({nm, " final_S_diffs"}, bad, 0);
    sb.delete();
  endtask

  initial begin
    vt[0] = '{"len0", 0, 0, {8'h00, 72'h0}, {8'h00, 72'h0}, 1, 3, 4, 1'b0};
    vt[1] = '{"ident", 0, 1, {8'h01, 8'h00, 64'h0}, {8'h01, 8'h02, 64'h0}, 2, 12, 16, 1'b0};
    vt[2] = '{"kat", 1, 9, 80'h09BBF316E8D940AF0AD3, 80'h09506C61696E74657874, 10, 84, 112, 1'b0};
    vt[3] = '{"max", 2, 255, 80'h0, 80'h0, 0, 2298, 3064, 1'b1};
    en[0] = 1'b0;
    en[1] = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    for (int u = 0; u < 2; u++) begin
      check("reset rdy", int'(rdy[u]), 1);
      check("reset s_wren", int'(s_wren[u]), 0);
      check("reset pt_wren", int'(pt_wren[u]), 0);
      check("reset s_addr", int'(s_addr[u]), 0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int u = 0; u < 2; u++) begin
      for (int v = 0; v < 4; v++) begin
        load_s(u, vt[v].s_kind);
        for (int x = 0; x < 256; x++) begin
          ct_mem[u][x] = 8'($urandom);
          pt_mem[u][x] = 8'hEE;
        end
        if (vt[v].len < 10)
          for (int b = 0; b < 10; b++) ct_mem[u][b] = vt[v].ct[79 - 8 * b -: 8];
        else
          ct_mem[u][0] = 8'(vt[v].len);
        start(u);
        finish(u, u == 0 ? vt[v].lat1 : vt[v].lat2, vt[v].pulse, vt[v].name);
        for (int b = 0; b < vt[v].npt; b++)
          check({vt[v].name, " pt_const"}, int'(pt_mem[u][b]), int'(vt[v].pt[79 - 8 * b -: 8]));
      end
      load_s(u, 2);
      for (int x = 0; x < 256; x++) ct_mem[u][x] = 8'($urandom);
      ct_mem[u][0] = 8'd20;
      start(u);
      repeat ((3 + u) + 2 * (9 + 3 * u) + 2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrun_reset rdy", int'(rdy[u]), 1);
      check("midrun_reset s_wren", int'(s_wren[u]), 0);
      check("midrun_reset pt_wren", int'(pt_wren[u]), 0);
      check("midrun_reset s_addr", int'(s_addr[u]), 0);
      check("midrun_reset pt_addr", int'(pt_addr[u]), 0);
      sb.delete();
      @(negedge clk) rst_n = 1'b1;
      load_s(u, 2);
      start(u);
      finish(u, u == 0 ? 3 + 9 * 20 : 4 + 12 * 20, 1'b0, "after_reset");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
